// File: rtl/div_arb_pkg.sv
// Shared types and constants for the divider arbiter: FSM state encoding,
// default widths, and the quotient bit used to fill a divide-by-zero result.
package div_arb_pkg;

    localparam int DEF_W    = 8;
    localparam int DEF_NREQ = 4;

    // A divide-by-zero returns an all-ones quotient; callers replicate this bit to W.
    localparam logic DZ_QBIT = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_DZ        = 3'd4,
        S_RESP      = 3'd5
    } state_t;

endpackage

// File: rtl/div_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or above rr_ptr,
// wrapping around, as a one-hot vector plus its index.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  rr_ptr,
    output logic            valid,
    output logic [NREQ-1:0] onehot,
    output logic [IDW-1:0]  idx
);

    int             k;
    logic [IDW-1:0] kk;

    always_comb begin
        valid  = 1'b0;
        onehot = '0;
        idx    = '0;
        k      = 0;
        kk     = '0;
        for (int i = 0; i < NREQ; i++) begin
            k  = (int'(rr_ptr) + i) % NREQ;
            kk = IDW'(k);
            if (!valid && req[kk]) begin
                valid      = 1'b1;
                onehot[kk] = 1'b1;
                idx        = kk;
            end
        end
    end

endmodule

// File: rtl/div_arbiter.sv
// Round-robin sequencer sharing one external divider among NREQ requesters;
// divide-by-zero is answered locally without starting the divider.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | arbitrate; grant only while the divider reports ready
// START     | div_start high for this single cycle
// WAIT_BUSY | wait for the divider to drop ready (it has accepted)
// WAIT_DONE | wait for ready to return, then capture the result
// DZ        | build the divide-by-zero response locally
// RESP      | rsp_valid pulse to the owner, back to IDLE
module div_arbiter
    import div_arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int W    = DEF_W,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ*W-1:0] req_dividend,
    input  logic [NREQ*W-1:0] req_divisor,
    output logic [NREQ-1:0]  gnt,
    output logic [NREQ-1:0]  rsp_valid,
    output logic [W-1:0]     rsp_quotient,
    output logic [W-1:0]     rsp_remainder,
    output logic             rsp_dz,
    output logic             busy,
    output logic             div_start,
    output logic [W-1:0]     div_dividend,
    output logic [W-1:0]     div_divisor,
    input  logic             div_ready,
    input  logic [W-1:0]     div_quotient,
    input  logic [W-1:0]     div_remainder
);

    state_t          state;
    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  owner;
    logic [NREQ-1:0] owner_onehot;

    logic            pick_valid;
    logic [NREQ-1:0] pick_onehot;
    logic [IDW-1:0]  pick_idx;
    logic [IDW-1:0]  next_ptr;
    logic            grant_now;
    logic [W-1:0]    sel_dividend;
    logic [W-1:0]    sel_divisor;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .valid  (pick_valid),
        .onehot (pick_onehot),
        .idx    (pick_idx)
    );

    // A divider that is not ready in IDLE is owned by someone else: hold off.
    assign grant_now = (state == S_IDLE) && pick_valid && div_ready;
    assign gnt       = grant_now ? pick_onehot : '0;
    assign next_ptr  = (int'(pick_idx) == NREQ - 1) ? '0 : pick_idx + 1'b1;

    always_comb begin
        sel_dividend = '0;
        sel_divisor  = '0;
        owner_onehot = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_idx == IDW'(i)) begin
                sel_dividend = req_dividend[i*W +: W];
                sel_divisor  = req_divisor[i*W +: W];
            end
            owner_onehot[i] = (owner == IDW'(i));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            rr_ptr        <= '0;
            owner         <= '0;
            rsp_valid     <= '0;
            rsp_quotient  <= '0;
            rsp_remainder <= '0;
            rsp_dz        <= 1'b0;
            busy          <= 1'b0;
            div_start     <= 1'b0;
            div_dividend  <= '0;
            div_divisor   <= '0;
        end else begin
            div_start <= 1'b0;
            rsp_valid <= '0;
            case (state)
                S_IDLE: begin
                    if (grant_now) begin
                        owner        <= pick_idx;
                        rr_ptr       <= next_ptr;
                        div_dividend <= sel_dividend;
                        div_divisor  <= sel_divisor;
                        busy         <= 1'b1;
                        if (sel_divisor == '0) begin
                            state <= S_DZ;
                        end else begin
                            state     <= S_START;
                            div_start <= 1'b1;
                        end
                    end
                end
                S_START: begin
                    state <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (!div_ready) begin
                        state <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (div_ready) begin
                        rsp_quotient  <= div_quotient;
                        rsp_remainder <= div_remainder;
                        rsp_dz        <= 1'b0;
                        rsp_valid     <= owner_onehot;
                        state         <= S_RESP;
                    end
                end
                S_DZ: begin
                    rsp_quotient  <= {W{DZ_QBIT}};
                    rsp_remainder <= div_dividend;
                    rsp_dz        <= 1'b1;
                    rsp_valid     <= owner_onehot;
                    state         <= S_RESP;
                end
                S_RESP: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_arbiter.sv
// Bench for div_arbiter: behavioural fixed-latency divider, directed requests,
// scoreboard queues for grants and responses checked by an independent monitor.
module tb_div_arbiter;

    localparam int NREQ    = 4;
    localparam int W       = 8;
    localparam int IDW     = 2;
    localparam int DIV_LAT = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] req_dividend;
    logic [NREQ*W-1:0] req_divisor;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   rsp_valid;
    logic [W-1:0]      rsp_quotient;
    logic [W-1:0]      rsp_remainder;
    logic              rsp_dz;
    logic              busy;
    logic              div_start;
    logic [W-1:0]      div_dividend;
    logic [W-1:0]      div_divisor;
    logic              div_ready;
    logic [W-1:0]      div_quotient;
    logic [W-1:0]      div_remainder;

    always #5 clk = ~clk;

    div_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .req_dividend  (req_dividend),
        .req_divisor   (req_divisor),
        .gnt           (gnt),
        .rsp_valid     (rsp_valid),
        .rsp_quotient  (rsp_quotient),
        .rsp_remainder (rsp_remainder),
        .rsp_dz        (rsp_dz),
        .busy          (busy),
        .div_start     (div_start),
        .div_dividend  (div_dividend),
        .div_divisor   (div_divisor),
        .div_ready     (div_ready),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder)
    );

    // Divider stand-in: drops ready the cycle after start, returns after DIV_LAT edges.
    logic       mdl_ready;
    logic [W-1:0] mdl_q, mdl_r, mdl_a, mdl_b;
    int         mdl_cnt;
    logic       ext_hold;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mdl_ready <= 1'b1;
            mdl_cnt   <= 0;
            mdl_q     <= '0;
            mdl_r     <= '0;
            mdl_a     <= '0;
            mdl_b     <= '0;
        end else if (mdl_ready && div_start) begin
            mdl_ready <= 1'b0;
            mdl_cnt   <= DIV_LAT;
            mdl_a     <= div_dividend;
            mdl_b     <= div_divisor;
        end else if (!mdl_ready) begin
            if (mdl_cnt == 1) begin
                mdl_ready <= 1'b1;
                mdl_q     <= mdl_a / mdl_b;
                mdl_r     <= mdl_a % mdl_b;
            end
            mdl_cnt <= mdl_cnt - 1;
        end
    end

    assign div_ready     = mdl_ready & ~ext_hold;
    assign div_quotient  = mdl_q;
    assign div_remainder = mdl_r;

    typedef struct {
        int         idx;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic       dz;
    } exp_t;

    exp_t rq[$];
    int   gq[$];
    int   errors = 0;
    int   checks = 0;
    int   n_gnt = 0;
    int   n_start = 0;
    int   cyc = 0;
    int   gcyc[NREQ];
    logic hold_req = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboards whenever the DUT presents a grant or response.
    initial begin : monitor
        logic [NREQ-1:0] prev_gnt;
        logic            prev_rsp;
        logic [NREQ-1:0] exp_oh;
        exp_t            e;
        int              g;
        prev_gnt = '0;
        prev_rsp = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                prev_gnt = '0;
                prev_rsp = 1'b0;
            end else begin
                if (gnt != '0) begin
                    n_gnt++;
                    if (gq.size() == 0) begin
                        chk("gnt_unexpected", 32'(gnt), 32'h0);
                    end else begin
                        g = gq.pop_front();
                        exp_oh = 4'b0001 << g;
                        chk("gnt_idx", 32'(gnt), 32'(exp_oh));
                        gcyc[g] = cyc;
                    end
                end
                if (div_start) begin
                    n_start++;
                    chk("start_after_gnt", 32'(prev_gnt != '0), 32'h1);
                end
                if (prev_rsp) chk("busy_after_rsp", 32'(busy), 32'h0);
                if (rsp_valid != '0) begin
                    chk("busy_in_rsp", 32'(busy), 32'h1);
                    if (rq.size() == 0) begin
                        chk("rsp_unexpected", 32'(rsp_valid), 32'h0);
                    end else begin
                        e = rq.pop_front();
                        exp_oh = 4'b0001 << e.idx;
                        chk("rsp_valid", 32'(rsp_valid), 32'(exp_oh));
                        chk("rsp_quotient", 32'(rsp_quotient), 32'(e.q));
                        chk("rsp_remainder", 32'(rsp_remainder), 32'(e.r));
                        chk("rsp_dz", 32'(rsp_dz), 32'(e.dz));
                        chk("rsp_latency", 32'(cyc - gcyc[e.idx]), e.dz ? 32'd2 : 32'(DIV_LAT + 3));
                    end
                end
                prev_gnt = gnt;
                prev_rsp = (rsp_valid != '0);
            end
        end
    end

    // Requesters drop their request once granted, unless the test holds them.
    initial begin : auto_drop
        logic [NREQ-1:0] g;
        forever begin
            @(negedge clk);
            g = gnt;
            if (g != '0 && !hold_req) begin
                @(posedge clk);
                #1;
                req = req & ~g;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_req(input int idx, input logic [W-1:0] a, input logic [W-1:0] b);
        req_dividend[idx*W +: W] = a;
        req_divisor[idx*W +: W]  = b;
        req[idx] = 1'b1;
    endtask

    task automatic expect_rsp(input int idx, input logic [W-1:0] q, input logic [W-1:0] r, input logic dz);
        exp_t e;
        e.idx = idx; e.q = q; e.r = r; e.dz = dz;
        gq.push_back(idx);
        rq.push_back(e);
    endtask

    task automatic wait_gnt(input int idx);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!gnt[idx] && n < 300);
        if (!gnt[idx]) chk("wait_gnt_timeout", 32'(idx), 32'hFFFF);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((rq.size() != 0 || gq.size() != 0 || busy) && n < 400);
        if (rq.size() != 0 || gq.size() != 0 || busy) chk("drain_timeout", 32'(rq.size()), 32'h0);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin : stimulus
        int start0;
        int n;
        req          = '0;
        req_dividend = '0;
        req_divisor  = '0;
        ext_hold     = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_div_start", 32'(div_start), 32'h0);
        chk("rst_rsp_quotient", 32'(rsp_quotient), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Single divide: 100/7 -> 14 r 2.
        start0 = n_start;
        @(posedge clk); #1;
        set_req(0, 8'd100, 8'd7);
        expect_rsp(0, 8'd14, 8'd2, 1'b0);
        wait_drain();
        chk("single_start_count", 32'(n_start - start0), 32'h1);

        // Round robin from reset with all four held: 0,1,2,3,0.
        pulse_reset();
        hold_req = 1'b1;
        set_req(0, 8'd100, 8'd7);
        set_req(1, 8'd255, 8'd16);
        set_req(2, 8'd17, 8'd17);
        set_req(3, 8'd5, 8'd9);
        expect_rsp(0, 8'd14, 8'd2, 1'b0);
        expect_rsp(1, 8'd15, 8'd15, 1'b0);
        expect_rsp(2, 8'd1, 8'd0, 1'b0);
        expect_rsp(3, 8'd0, 8'd5, 1'b0);
        expect_rsp(0, 8'd14, 8'd2, 1'b0);
        n = 0;
        start0 = n_gnt;
        while (n_gnt - start0 < 5 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("rr_grant_count", 32'(n_gnt - start0), 32'd5);
        @(posedge clk);
        #1 req = '0;
        hold_req = 1'b0;
        wait_drain();

        // Grant to 3, then 0 and 2 together: 0 wins by wrap-around, then 2.
        @(posedge clk); #1;
        set_req(3, 8'd200, 8'd10);
        expect_rsp(3, 8'd20, 8'd0, 1'b0);
        wait_gnt(3);
        @(posedge clk); #1;
        set_req(0, 8'd50, 8'd6);
        set_req(2, 8'd81, 8'd9);
        expect_rsp(0, 8'd8, 8'd2, 1'b0);
        expect_rsp(2, 8'd9, 8'd0, 1'b0);
        wait_drain();

        // Divide by zero: 55/0 -> all ones, remainder = dividend, no divider start.
        start0 = n_start;
        @(posedge clk); #1;
        set_req(1, 8'd55, 8'd0);
        expect_rsp(1, 8'hFF, 8'd55, 1'b1);
        wait_drain();
        chk("dz_no_start", 32'(n_start - start0), 32'h0);

        // Reset in WAIT_DONE aborts 200/3 silently.
        @(posedge clk); #1;
        set_req(0, 8'd200, 8'd3);
        gq.push_back(0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (div_ready && n < 100);
        chk("abort_div_busy", 32'(div_ready), 32'h0);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("abort_rsp_quotient", 32'(rsp_quotient), 32'h0);
        chk("abort_rsp_remainder", 32'(rsp_remainder), 32'h0);
        chk("abort_rsp_dz", 32'(rsp_dz), 32'h0);
        chk("abort_div_dividend", 32'(div_dividend), 32'h0);
        chk("abort_div_divisor", 32'(div_divisor), 32'h0);
        chk("abort_rr_ptr", 32'(dut.rr_ptr), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        set_req(2, 8'd9, 8'd4);
        expect_rsp(2, 8'd2, 8'd1, 1'b0);
        wait_drain();

        // Request arriving while busy, then divider held not-ready in IDLE.
        @(posedge clk); #1;
        set_req(1, 8'd30, 8'd4);
        expect_rsp(1, 8'd7, 8'd2, 1'b0);
        wait_gnt(1);
        @(posedge clk); #1;
        set_req(2, 8'd60, 8'd7);
        expect_rsp(2, 8'd8, 8'd4, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid[1] && n < 100);
        ext_hold = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("stall_no_gnt", 32'(gnt), 32'h0);
        end
        @(posedge clk);
        #1 ext_hold = 1'b0;
        @(negedge clk);
        chk("gnt_on_ready", 32'(gnt), 32'h4);
        wait_drain();

        repeat (3) @(negedge clk);
        chk("final_gq_empty", 32'(gq.size()), 32'h0);
        chk("final_rq_empty", 32'(rq.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
